// File: rtl/overlay_chram_arb_if.sv
// ---------------------------------------------------------------------------
// overlay_chram_arb_if
//
// Purpose:
//   Bundles everything exchanged between the overlay character-RAM
//   arbiter and the outside world except clock and reset. This covers the
//   three requesters (gear animator, progress bar, text/counter printer),
//   the write-window qualifier, the grant/accept handshake, and the
//   registered write port into the character RAM.
//
// Signals:
//   wr_allow      write window (e.g. vertical blank); ignored unless gated
//   req[2:0]      per-requester write request
//   last[2:0]     per-requester "this beat ends the burst" flag
//   addr0..addr2  per-requester 12-bit character-RAM address
//   data0..data2  per-requester 8-bit character code
//   ack[2:0]      combinational beat accept, one-hot or zero
//   gnt[2:0]      registered grant owner, one-hot or zero
//   busy          registered, high while a burst owns the RAM port
//   wr_ena        registered write strobe to the character RAM
//   wr_addr       registered write address
//   wr_data       registered write data
//
// Modports:
//   master  requesters / RAM side (drives requests, observes grants)
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface overlay_chram_arb_if;

  logic        wr_allow;
  logic [2:0]  req;
  logic [2:0]  last;
  logic [11:0] addr0;
  logic [11:0] addr1;
  logic [11:0] addr2;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic [2:0]  ack;
  logic [2:0]  gnt;
  logic        busy;
  logic        wr_ena;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (
    output wr_allow,
    output req,
    output last,
    output addr0,
    output addr1,
    output addr2,
    output data0,
    output data1,
    output data2,
    input  ack,
    input  gnt,
    input  busy,
    input  wr_ena,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  wr_allow,
    input  req,
    input  last,
    input  addr0,
    input  addr1,
    input  addr2,
    input  data0,
    input  data1,
    input  data2,
    output ack,
    output gnt,
    output busy,
    output wr_ena,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/overlay_chram_arb.sv
// ---------------------------------------------------------------------------
// overlay_chram_arb
//
// Purpose:
//   Round-robin arbiter that shares the single write port of the overlay
//   character RAM between three requesters: 0 = gear animator,
//   1 = progress bar, 2 = text/counter printer. A requester that wins
//   arbitration owns the port for a burst of beats. Each accepted beat
//   (ack) is written to the RAM one cycle later through registered
//   wr_ena/wr_addr/wr_data.
//
//   A burst ends on the beat flagged with last, on the beat that reaches
//   MAX_BURST accepted beats, or when the owner drops its request before
//   a beat is accepted. A one-cycle IDLE gap always separates bursts. The
//   round-robin pointer then moves to the requester after the one just
//   served.
//
//   With GATE_EN=1, nothing is granted or accepted outside the wr_allow
//   window. A burst that is in flight is frozen, not cancelled.
//
// Parameters:
//   MAX_BURST  maximum accepted beats per grant (1..32)
//   GATE_EN    1: honour wr_allow; 0: wr_allow is ignored
//
// Ports:
//   i_clk  clock for all logic
//   reset  synchronous, active-high reset
//   bus    overlay_chram_arb_if.slave (requests, handshake, RAM write port)
// ---------------------------------------------------------------------------
module overlay_chram_arb #(
  parameter int unsigned MAX_BURST = 16,
  parameter bit          GATE_EN   = 1'b0
) (
  input  logic               i_clk,
  input  logic               reset,
  overlay_chram_arb_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  gnt_q;
  logic [2:0]  gnt_nx;
  logic [1:0]  rr_ptr;
  logic [1:0]  rr_ptr_nx;
  logic [4:0]  bcnt;
  logic [4:0]  bcnt_nx;
  logic        busy_q;

  logic        wr_ena_q;
  logic [11:0] wr_addr_q;
  logic [7:0]  wr_data_q;

  logic        gate_open;
  logic [2:0]  ack;
  logic [1:0]  own_idx;
  logic        own_req;
  logic        own_last;
  logic [11:0] own_addr;
  logic [7:0]  own_data;
  logic        beat_limit;
  logic        release_burst;

  logic [1:0]  cand0;
  logic [1:0]  cand1;
  logic [1:0]  cand2;
  logic        pick_valid;
  logic [1:0]  pick_idx;

  // Modulo-3 successor. The pointer never holds 3, but that code folds
  // onto 0 so that a corrupted value recovers by itself.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Select one requester bit by index. Index 3 reads as "not requesting".
  function automatic logic bit_at(input logic [2:0] vec, input logic [1:0] idx);
    logic b;
    case (idx)
      2'd0:    b = vec[0];
      2'd1:    b = vec[1];
      2'd2:    b = vec[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    logic [2:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // The window only matters when gating is enabled.
  assign gate_open = !GATE_EN || bus.wr_allow;

  // Index of the current owner. gnt_q is one-hot or zero, and the zero
  // case is harmless because the index is used only while BUSY.
  always_comb begin
    own_idx = 2'd0;
    if (gnt_q[1]) begin
      own_idx = 2'd1;
    end else if (gnt_q[2]) begin
      own_idx = 2'd2;
    end
  end

  // Route the owner's request, last flag, address and data. Inputs of
  // the other requesters never reach the write port.
  always_comb begin
    own_addr = bus.addr0;
    own_data = bus.data0;
    case (own_idx)
      2'd1: begin
        own_addr = bus.addr1;
        own_data = bus.data1;
      end
      2'd2: begin
        own_addr = bus.addr2;
        own_data = bus.data2;
      end
      default: begin
      end
    endcase
  end

  assign own_req  = bit_at(bus.req, own_idx);
  assign own_last = bit_at(bus.last, own_idx);

  // Widened compare so that MAX_BURST=32 still fits after the increment.
  assign beat_limit = (({1'b0, bcnt} + 6'd1) == 6'(MAX_BURST));

  // Accept the owner's beat only while holding the port with the window
  // open. Reset masks ack immediately, even though the state registers
  // only clear on the edge.
  always_comb begin
    ack = 3'b000;
    if (!reset && (state == BUSY) && gate_open) begin
      ack = gnt_q & bus.req;
    end
  end

  // Round-robin search. Try rr_ptr first, then the next two requesters
  // in modulo-3 order.
  always_comb begin
    cand0      = (rr_ptr > 2'd2) ? 2'd0 : rr_ptr;
    cand1      = next_idx(cand0);
    cand2      = next_idx(cand1);
    pick_valid = 1'b1;
    pick_idx   = cand0;
    if (bit_at(bus.req, cand0)) begin
      pick_idx = cand0;
    end else if (bit_at(bus.req, cand1)) begin
      pick_idx = cand1;
    end else if (bit_at(bus.req, cand2)) begin
      pick_idx = cand2;
    end else begin
      pick_valid = 1'b0;
    end
  end

  // Next-state logic. IDLE grants when someone asks and the window is
  // open. BUSY counts accepted beats and releases on last, on the beat
  // limit, or on an abandoned request. A closed window freezes BUSY
  // entirely, including abandonment, so that a paused burst resumes
  // intact. A release always passes through IDLE, which creates the
  // one-cycle arbitration bubble.
  always_comb begin
    state_nx      = state;
    gnt_nx        = gnt_q;
    rr_ptr_nx     = rr_ptr;
    bcnt_nx       = bcnt;
    release_burst = 1'b0;
    case (state)
      IDLE: begin
        if (gate_open && pick_valid) begin
          state_nx = BUSY;
          gnt_nx   = one_hot(pick_idx);
          bcnt_nx  = 5'd0;
        end
      end
      BUSY: begin
        if (gate_open) begin
          if (!own_req) begin
            release_burst = 1'b1;
          end else begin
            bcnt_nx = bcnt + 5'd1;
            if (own_last || beat_limit) begin
              release_burst = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 3'b000;
      end
    endcase
    if (release_burst) begin
      state_nx  = IDLE;
      gnt_nx    = 3'b000;
      rr_ptr_nx = next_idx(own_idx);
    end
  end

  // Control registers: FSM state, grant, pointer, beat count and busy.
  // Reset wins over any burst in flight.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= 3'b000;
      rr_ptr <= 2'd0;
      bcnt   <= 5'd0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      gnt_q  <= gnt_nx;
      rr_ptr <= rr_ptr_nx;
      bcnt   <= bcnt_nx;
      busy_q <= (state_nx == BUSY);
    end
  end

  // Write port: one cycle of latency from ack. Address and data hold
  // between writes so that the RAM side sees stable values.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      wr_ena_q  <= 1'b0;
      wr_addr_q <= 12'd0;
      wr_data_q <= 8'd0;
    end else begin
      wr_ena_q <= |ack;
      if (|ack) begin
        wr_addr_q <= own_addr;
        wr_data_q <= own_data;
      end
    end
  end

  assign bus.ack     = ack;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.wr_ena  = wr_ena_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_overlay_chram_arb.sv
// ---------------------------------------------------------------------------
// tb_overlay_chram_arb
//
// Purpose:
//   Self-checking bench for overlay_chram_arb. Two instances share the
//   same stimulus. One has gating enabled and one ignores wr_allow. Each
//   instance is paired with a transaction-level reference model: who owns
//   the port, how many beats that owner has had, and who is next in line.
//   Every cycle, all outputs of both instances are compared with their
//   models. Directed scenarios add fixed-value checks on the gated
//   instance. A long randomised run follows.
// ---------------------------------------------------------------------------
module tb_overlay_chram_arb;

  localparam int TB_MAX = 16;
  localparam logic [2:0] RR_EXP [8] = '{3'b000, 3'b001, 3'b000, 3'b010,
                                        3'b000, 3'b100, 3'b000, 3'b001};

  logic        i_clk;
  logic        reset;
  logic        wr_allow;
  logic [2:0]  req;
  logic [2:0]  last;
  logic [11:0] addr_in [3];
  logic [7:0]  data_in [3];

  int vectors;
  int miscompares;

  logic [2:0]  cap_ack;
  logic [2:0]  cap_gnt;
  logic        cap_busy;
  logic        cap_wr_ena;
  logic [11:0] cap_wr_addr;
  logic [7:0]  cap_wr_data;

  // Reference model state, index 0 = gated instance, 1 = ungated instance.
  int          m_owner [2];
  int          m_beats [2];
  int          m_ptr   [2];
  logic        m_wr_ena  [2];
  logic [11:0] m_wr_addr [2];
  logic [7:0]  m_wr_data [2];

  overlay_chram_arb_if bus_g ();
  overlay_chram_arb_if bus_n ();

  assign bus_g.wr_allow = wr_allow;
  assign bus_g.req      = req;
  assign bus_g.last     = last;
  assign bus_g.addr0    = addr_in[0];
  assign bus_g.addr1    = addr_in[1];
  assign bus_g.addr2    = addr_in[2];
  assign bus_g.data0    = data_in[0];
  assign bus_g.data1    = data_in[1];
  assign bus_g.data2    = data_in[2];

  assign bus_n.wr_allow = wr_allow;
  assign bus_n.req      = req;
  assign bus_n.last     = last;
  assign bus_n.addr0    = addr_in[0];
  assign bus_n.addr1    = addr_in[1];
  assign bus_n.addr2    = addr_in[2];
  assign bus_n.data0    = data_in[0];
  assign bus_n.data1    = data_in[1];
  assign bus_n.data2    = data_in[2];

  overlay_chram_arb #(.MAX_BURST(TB_MAX), .GATE_EN(1'b1)) dut_g (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (bus_g)
  );

  overlay_chram_arb #(.MAX_BURST(TB_MAX), .GATE_EN(1'b0)) dut_n (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (bus_n)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit gateEn(input int k);
    return (k == 0);
  endfunction

  task automatic modelReset(input int k);
    m_owner[k]   = -1;
    m_beats[k]   = 0;
    m_ptr[k]     = 0;
    m_wr_ena[k]  = 1'b0;
    m_wr_addr[k] = 12'd0;
    m_wr_data[k] = 8'd0;
  endtask

  // A beat is accepted when someone owns the port, the window is open
  // (or ignored), the owner is asking, and reset is low.
  function automatic logic [2:0] modelAck(input int k);
    if (reset || m_owner[k] < 0) return 3'b000;
    if (gateEn(k) && !wr_allow) return 3'b000;
    if (!req[m_owner[k]]) return 3'b000;
    return 3'(1 << m_owner[k]);
  endfunction

  task automatic releaseOwner(input int k);
    m_ptr[k]   = (m_owner[k] + 1) % 3;
    m_owner[k] = -1;
  endtask

  task automatic modelStep(input int k, input logic [2:0] ea);
    bit open_w;
    bit found;
    int c;
    open_w = !gateEn(k) || wr_allow;
    if (reset) begin
      modelReset(k);
      return;
    end
    m_wr_ena[k] = (ea != 3'b000);
    if (ea != 3'b000) begin
      m_wr_addr[k] = addr_in[m_owner[k]];
      m_wr_data[k] = data_in[m_owner[k]];
      m_beats[k]++;
      if (last[m_owner[k]] || m_beats[k] == TB_MAX) releaseOwner(k);
    end else if (m_owner[k] >= 0) begin
      if (open_w && !req[m_owner[k]]) releaseOwner(k);
    end else if (open_w) begin
      found = 1'b0;
      for (int j = 0; j < 3; j++) begin
        c = (m_ptr[k] + j) % 3;
        if (!found && req[c]) begin
          found      = 1'b1;
          m_owner[k] = c;
          m_beats[k] = 0;
        end
      end
    end
  endtask

  task automatic checkInstance(input int k, input logic [2:0] a, input logic [2:0] g,
                               input logic b, input logic e, input logic [11:0] wa,
                               input logic [7:0] wd);
    string p;
    logic [2:0] eg;
    p  = (k == 0) ? "gated" : "ungated";
    eg = (m_owner[k] < 0) ? 3'b000 : 3'(1 << m_owner[k]);
    checkOutput({p, "_ack"},     32'(a),  32'(modelAck(k)));
    checkOutput({p, "_gnt"},     32'(g),  32'(eg));
    checkOutput({p, "_busy"},    32'(b),  32'(m_owner[k] >= 0));
    checkOutput({p, "_wr_ena"},  32'(e),  32'(m_wr_ena[k]));
    checkOutput({p, "_wr_addr"}, 32'(wa), 32'(m_wr_addr[k]));
    checkOutput({p, "_wr_data"}, 32'(wd), 32'(m_wr_data[k]));
  endtask

  // One clock cycle. Drive the inputs, let them settle, check both
  // instances against their models, advance the models, and wait for the
  // next negedge.
  task automatic applyStimulus(input logic rst, input logic [2:0] rq,
                               input logic [2:0] ls, input logic allow);
    logic [2:0] ea0;
    logic [2:0] ea1;
    reset    = rst;
    req      = rq;
    last     = ls;
    wr_allow = allow;
    #2;
    cap_ack     = bus_g.ack;
    cap_gnt     = bus_g.gnt;
    cap_busy    = bus_g.busy;
    cap_wr_ena  = bus_g.wr_ena;
    cap_wr_addr = bus_g.wr_addr;
    cap_wr_data = bus_g.wr_data;
    checkInstance(0, bus_g.ack, bus_g.gnt, bus_g.busy, bus_g.wr_ena, bus_g.wr_addr, bus_g.wr_data);
    checkInstance(1, bus_n.ack, bus_n.gnt, bus_n.busy, bus_n.wr_ena, bus_n.wr_addr, bus_n.wr_data);
    ea0 = modelAck(0);
    ea1 = modelAck(1);
    modelStep(0, ea0);
    modelStep(1, ea1);
    @(negedge i_clk);
  endtask

  logic [11:0] wq [$];
  logic [2:0]  gq [$];
  logic [2:0]  rr_seen [8];

  initial begin
    int r0;
    int r1;
    int closed;
    int first_beats;
    bit seen_grant;
    bit first_done;
    bit served0;
    bit served2;
    logic [2:0] rq;
    logic [2:0] ls;
    logic [2:0] prev_gnt;
    logic allow;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    wr_allow    = 1'b1;
    req         = 3'b000;
    last        = 3'b000;
    for (int j = 0; j < 3; j++) begin
      addr_in[j] = 12'd0;
      data_in[j] = 8'd0;
    end
    modelReset(0);
    modelReset(1);
    @(negedge i_clk);

    // Reset state
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    checkOutput("rst_gnt", 32'(cap_gnt), 32'd0);
    checkOutput("rst_busy", 32'(cap_busy), 32'd0);
    checkOutput("rst_wr_ena", 32'(cap_wr_ena), 32'd0);
    checkOutput("rst_ack", 32'(cap_ack), 32'd0);

    // Single write from requester 0
    addr_in[0] = 12'd331;
    data_in[0] = 8'h2A;
    applyStimulus(1'b0, 3'b001, 3'b001, 1'b1);
    checkOutput("single_idle_gnt", 32'(cap_gnt), 32'd0);
    applyStimulus(1'b0, 3'b001, 3'b001, 1'b1);
    checkOutput("single_gnt", 32'(cap_gnt), 32'b001);
    checkOutput("single_ack", 32'(cap_ack), 32'b001);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    checkOutput("single_wr_ena", 32'(cap_wr_ena), 32'd1);
    checkOutput("single_wr_addr", 32'(cap_wr_addr), 32'd331);
    checkOutput("single_wr_data", 32'(cap_wr_data), 32'h2A);
    checkOutput("single_release", 32'(cap_gnt), 32'd0);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    checkOutput("single_wr_once", 32'(cap_wr_ena), 32'd0);
    checkOutput("single_addr_hold", 32'(cap_wr_addr), 32'd331);
    // The pointer now sits on requester 1, so 1 beats 0.
    applyStimulus(1'b0, 3'b011, 3'b011, 1'b1);
    applyStimulus(1'b0, 3'b011, 3'b011, 1'b1);
    checkOutput("single_ptr_next", 32'(cap_gnt), 32'b010);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);

    // Round robin with all three requesting single-beat bursts
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 3'b111, 3'b111, 1'b1);
      rr_seen[c] = cap_gnt;
    end
    for (int c = 0; c < 8; c++) checkOutput($sformatf("rr_gnt_%0d", c), 32'(rr_seen[c]), 32'(RR_EXP[c]));
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);

    // Forced release: requester 1 asks for 20 beats without last
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    r1 = 0; served0 = 1'b0; served2 = 1'b0; prev_gnt = 3'b000;
    wq.delete(); gq.delete();
    addr_in[0] = 12'h700; data_in[0] = 8'hA0;
    addr_in[2] = 12'h702; data_in[2] = 8'hA2;
    for (int c = 0; c < 40; c++) begin
      addr_in[1] = 12'(136 + r1);
      data_in[1] = 8'(r1);
      rq[1] = (r1 < 20);
      rq[0] = (gq.size() > 0) && !served0;
      rq[2] = (gq.size() > 0) && !served2;
      ls    = {1'b1, (r1 == 19), 1'b1};
      applyStimulus(1'b0, rq, ls, 1'b1);
      if (cap_ack[1]) r1++;
      if (cap_ack[0]) served0 = 1'b1;
      if (cap_ack[2]) served2 = 1'b1;
      if (cap_gnt != 3'b000 && cap_gnt != prev_gnt) gq.push_back(cap_gnt);
      prev_gnt = cap_gnt;
      if (cap_wr_ena) wq.push_back(cap_wr_addr);
    end
    checkOutput("force_grants", 32'(gq.size()), 32'd4);
    checkOutput("force_writes", 32'(wq.size()), 32'd22);
    if (gq.size() == 4) begin
      checkOutput("force_g0", 32'(gq[0]), 32'b010);
      checkOutput("force_g1", 32'(gq[1]), 32'b100);
      checkOutput("force_g2", 32'(gq[2]), 32'b001);
      checkOutput("force_g3", 32'(gq[3]), 32'b010);
    end
    if (wq.size() == 22) begin
      for (int i = 0; i < 16; i++) checkOutput($sformatf("force_addr_%0d", i), 32'(wq[i]), 32'(136 + i));
      checkOutput("force_addr_r2", 32'(wq[16]), 32'h702);
      checkOutput("force_addr_r0", 32'(wq[17]), 32'h700);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("force_tail_%0d", i), 32'(wq[18 + i]), 32'(152 + i));
    end

    // Gating: the window closes for 4 cycles after 3 accepted beats
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    r0 = 0; closed = 0; first_beats = 0; seen_grant = 1'b0; first_done = 1'b0;
    wq.delete();
    for (int c = 0; c < 50; c++) begin
      addr_in[0] = 12'(12'h200 + r0);
      data_in[0] = 8'(r0) ^ 8'h5A;
      allow = !(r0 >= 3 && closed < 4);
      rq    = {2'b00, (r0 < 18)};
      applyStimulus(1'b0, rq, 3'b000, allow);
      if (!allow) begin
        closed++;
        checkOutput("gate_ack", 32'(cap_ack), 32'd0);
        checkOutput("gate_gnt_hold", 32'(cap_gnt), 32'b001);
        if (closed > 1) checkOutput("gate_wr_ena", 32'(cap_wr_ena), 32'd0);
      end
      if (cap_ack[0]) begin
        r0++;
        if (!first_done) first_beats++;
      end
      if (cap_gnt != 3'b000) seen_grant = 1'b1;
      if (seen_grant && cap_gnt == 3'b000) first_done = 1'b1;
      if (cap_wr_ena) wq.push_back(cap_wr_addr);
    end
    checkOutput("gate_first_burst", 32'(first_beats), 32'(TB_MAX));
    checkOutput("gate_writes", 32'(wq.size()), 32'd18);
    if (wq.size() == 18) begin
      for (int i = 0; i < 18; i++) checkOutput($sformatf("gate_addr_%0d", i), 32'(wq[i]), 32'(12'h200 + i));
    end

    // Abandoned burst by requester 2
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    applyStimulus(1'b0, 3'b100, 3'b000, 1'b1);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    checkOutput("abandon_gnt", 32'(cap_gnt), 32'b100);
    checkOutput("abandon_ack", 32'(cap_ack), 32'd0);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    checkOutput("abandon_wr_ena", 32'(cap_wr_ena), 32'd0);
    checkOutput("abandon_busy", 32'(cap_busy), 32'd0);
    applyStimulus(1'b0, 3'b110, 3'b110, 1'b1);
    applyStimulus(1'b0, 3'b110, 3'b110, 1'b1);
    checkOutput("abandon_ptr0", 32'(cap_gnt), 32'b010);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);

    // Reset in the middle of a burst, on its 5th beat
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    r1 = 0;
    for (int c = 0; c < 12 && r1 < 4; c++) begin
      addr_in[1] = 12'(12'h301 + r1);
      data_in[1] = 8'(r1 + 1);
      applyStimulus(1'b0, 3'b010, 3'b000, 1'b1);
      if (cap_ack[1]) r1++;
    end
    checkOutput("midrst_beats", 32'(r1), 32'd4);
    addr_in[1] = 12'h305;
    applyStimulus(1'b1, 3'b011, 3'b000, 1'b1);
    checkOutput("midrst_ack", 32'(cap_ack), 32'd0);
    applyStimulus(1'b0, 3'b011, 3'b011, 1'b1);
    checkOutput("midrst_wr_ena", 32'(cap_wr_ena), 32'd0);
    checkOutput("midrst_gnt", 32'(cap_gnt), 32'd0);
    checkOutput("midrst_busy", 32'(cap_busy), 32'd0);
    checkOutput("midrst_wr_addr", 32'(cap_wr_addr), 32'd0);
    applyStimulus(1'b0, 3'b011, 3'b011, 1'b1);
    checkOutput("midrst_req0_first", 32'(cap_gnt), 32'b001);
    applyStimulus(1'b1, 3'b010, 3'b010, 1'b1);
    applyStimulus(1'b0, 3'b010, 3'b010, 1'b1);
    applyStimulus(1'b0, 3'b010, 3'b010, 1'b1);
    checkOutput("midrst_req1_alone", 32'(cap_gnt), 32'b010);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);

    // Randomised traffic checked cycle by cycle against the models
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 3; j++) begin
        addr_in[j] = 12'($urandom);
        data_in[j] = 8'($urandom);
      end
      if (c < 1500) begin
        rq = 3'($urandom) | 3'($urandom);
        ls = 3'($urandom) & 3'($urandom);
      end else begin
        rq = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b111;
        ls = ($urandom_range(0, 19) == 0) ? 3'b111 : 3'b000;
      end
      applyStimulus($urandom_range(0, 249) == 0, rq, ls, $urandom_range(0, 5) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
